cpu_ddr_pipeline_bridge: RTL and testbench
==========================================

CPU_DDR_PIPELINE_BRIDGE -- requirements
Module: cpu_ddr_pipeline_bridge

Interface
REQ-001 SHALL have parameter MAX_PENDING_READS, default 8, maximum reads issued on m1 and not yet returned.
REQ-002 SHALL have parameter ADDR_W, default 23, word-address width on both s1 and m1.
REQ-003 SHALL use one clock and a synchronous, active-high reset: clk (in, 1) and reset (in, 1), both sampled on the rising edge of clk.
REQ-004 s1 ports (CPU-facing Avalon slave):
- slave_address  in  ADDR_W  word address
- slave_nativeaddress  in  ADDR_W  native address
- slave_byteenable  in  4  byte lanes
- slave_read  in  1  read request
- slave_write  in  1  write request
- slave_writedata  in  32  write data
- slave_waitrequest  out  1  stall
- slave_readdata  out  32  read data
- slave_readdatavalid  out  1  read data valid
- slave_endofpacket  out  1  end of packet
REQ-005 m1 ports (toward the DDR clock-crossing bridge slave):
- master_address  out  ADDR_W  word address
- master_nativeaddress  out  ADDR_W  native address
- master_byteenable  out  4  byte lanes
- master_read  out  1  read request
- master_write  out  1  write request
- master_writedata  out  32  write data
- master_waitrequest  in  1  stall
- master_readdata  in  32  read data
- master_readdatavalid  in  1  read data valid
- master_endofpacket  in  1  end of packet

Function
REQ-006 Command path SHALL be a 2-entry skid buffer: output register (OR) drives m1; skid register (SK) holds one overflow command.
- Each entry stores address, nativeaddress, byteenable, writedata, rd and wr flags, and a valid bit.
REQ-007 slave_waitrequest SHALL be a registered copy of SK valid and SHALL NOT depend combinationally on master_waitrequest.
REQ-008 s1 accept SHALL occur when (slave_read | slave_write) & !slave_waitrequest.
REQ-009 If slave_read and slave_write are both high at accept, the bridge SHALL store a write only.
REQ-010 An accepted command SHALL appear on m1 on the next cycle when OR is empty or draining that cycle; otherwise it SHALL load SK.
REQ-011 Issue SHALL occur when OR is valid and not blocked. OR is blocked when master_waitrequest=1, or when OR holds a read and pending==MAX_PENDING_READS.
REQ-012 On issue, OR SHALL reload from SK if SK is valid, else from the s1 accept of that cycle, else go empty.
REQ-013 While blocked, all m1 command outputs SHALL hold stable.
- master_read/master_write SHALL be low while OR is empty.
- master_read SHALL be forced low while the read-limit block is active.
- Issue is strictly in order: a write queued behind a blocked read also waits.
REQ-014 pending counter SHALL be clog2(MAX_PENDING_READS+1) bits wide.
- Increment on read issue (master_read & !master_waitrequest).
- Decrement on master_readdatavalid.
- Both in the same cycle: no change.
REQ-015 A decrement with pending==0 SHALL leave pending at 0, and the response SHALL still be forwarded.
REQ-016 Response path SHALL register master_readdata, master_readdatavalid and master_endofpacket to the s1 outputs with exactly 1-cycle latency, with no backpressure.
REQ-017 A read issued in cycle N (pending==MAX-1, no return) SHALL make pending==MAX in N+1; a read then sitting in OR SHALL NOT assert master_read until a readdatavalid has been observed.

Reset
REQ-018 While reset=1 at a clock edge, OR and SK valid bits, pending, slave_waitrequest, slave_readdatavalid, master_read and master_write SHALL clear to 0.
REQ-019 While reset=1 at a clock edge, slave_readdata and slave_endofpacket SHALL clear to 0; data fields in OR/SK need not be reset.
REQ-020 Reset asserted mid-operation SHALL discard queued commands and the pending count, with no m1 command issued in the cycle after reset deasserts.

Verification
REQ-021 Single write, master_waitrequest=0: write addr 0x000010, data 0xDEADBEEF, be 0xF -> master_write=1 with the same fields exactly 1 cycle later, for 1 cycle; slave_waitrequest stays 0.
REQ-022 Stall: hold master_waitrequest=1 while issuing 3 back-to-back writes -> first held on m1, second in SK, slave_waitrequest=1 from the cycle after the second accept; release -> all 3 issued in order on consecutive cycles.
REQ-023 Read limit: issue 9 reads with MAX=8 and no readdatavalid -> 8 issued, 9th held with master_read=0; one readdatavalid -> 9th issued the next cycle, pending back to 8.
REQ-024 Response: master_readdatavalid=1, master_readdata=0x12345678, master_endofpacket=1 -> slave_readdatavalid=1, slave_readdata=0x12345678, slave_endofpacket=1 one cycle later; simultaneous issue+return keeps pending unchanged.
REQ-025 Reset mid-stall: with OR and SK full, assert reset 1 cycle -> next cycle master_read=master_write=0, slave_waitrequest=0, pending=0.
REQ-026 Read+write both high at accept -> exactly one master_write issued, no master_read, pending unchanged; spurious readdatavalid at pending=0 -> forwarded, pending stays 0.

Source files
------------

// File: rtl/cpu_ddr_pipeline_bridge.sv
// CPU-facing Avalon pipeline bridge toward the DDR clock-crossing bridge.
// Two-entry skid-buffered command path with a bounded count of outstanding reads.
module cpu_ddr_pipeline_bridge #(
    parameter int MAX_PENDING_READS = 8,
    parameter int ADDR_W            = 23
) (
    input  logic              clk,
    input  logic              reset,
    // s1: CPU-facing slave
    input  logic [ADDR_W-1:0] slave_address,
    input  logic [ADDR_W-1:0] slave_nativeaddress,
    input  logic [3:0]        slave_byteenable,
    input  logic              slave_read,
    input  logic              slave_write,
    input  logic [31:0]       slave_writedata,
    output logic              slave_waitrequest,
    output logic [31:0]       slave_readdata,
    output logic              slave_readdatavalid,
    output logic              slave_endofpacket,
    // m1: toward the DDR bridge
    output logic [ADDR_W-1:0] master_address,
    output logic [ADDR_W-1:0] master_nativeaddress,
    output logic [3:0]        master_byteenable,
    output logic              master_read,
    output logic              master_write,
    output logic [31:0]       master_writedata,
    input  logic              master_waitrequest,
    input  logic [31:0]       master_readdata,
    input  logic              master_readdatavalid,
    input  logic              master_endofpacket
);

    localparam int PW = $clog2(MAX_PENDING_READS + 1);
    localparam logic [PW-1:0] PEND_MAX = PW'(MAX_PENDING_READS);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [ADDR_W-1:0] naddr;
        logic [3:0]        be;
        logic [31:0]       wdata;
        logic              rd;
        logic              wr;
    } cmd_t;

    cmd_t          in_cmd, or_cmd, sk_cmd, or_cmd_nxt, sk_cmd_nxt;
    logic          or_valid, sk_valid, or_valid_nxt, sk_valid_nxt;
    logic [PW-1:0] pending;
    logic          accept, issue, read_limited, rd_issue;

    // A simultaneous read+write request is stored as a write only.
    always_comb begin
        in_cmd.addr  = slave_address;
        in_cmd.naddr = slave_nativeaddress;
        in_cmd.be    = slave_byteenable;
        in_cmd.wdata = slave_writedata;
        in_cmd.wr    = slave_write;
        in_cmd.rd    = slave_read & ~slave_write;
    end

    assign accept       = (slave_read | slave_write) & ~slave_waitrequest;
    assign read_limited = or_cmd.rd & (pending == PEND_MAX);
    assign issue        = or_valid & ~master_waitrequest & ~read_limited;
    assign rd_issue     = master_read & ~master_waitrequest;

    assign master_address       = or_cmd.addr;
    assign master_nativeaddress = or_cmd.naddr;
    assign master_byteenable    = or_cmd.be;
    assign master_writedata     = or_cmd.wdata;
    assign master_read          = or_valid & or_cmd.rd & ~read_limited;
    assign master_write         = or_valid & or_cmd.wr;

    always_comb begin
        or_cmd_nxt   = or_cmd;
        or_valid_nxt = or_valid;
        sk_cmd_nxt   = sk_cmd;
        sk_valid_nxt = sk_valid;
        if (!or_valid || issue) begin
            // OR is free this cycle: refill from SK first to keep order
            if (sk_valid) begin
                or_cmd_nxt   = sk_cmd;
                or_valid_nxt = 1'b1;
                sk_cmd_nxt   = in_cmd;
                sk_valid_nxt = accept;
            end else begin
                or_cmd_nxt   = in_cmd;
                or_valid_nxt = accept;
            end
        end else if (accept) begin
            sk_cmd_nxt   = in_cmd;
            sk_valid_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        or_cmd <= or_cmd_nxt;
        sk_cmd <= sk_cmd_nxt;
        if (reset) begin
            or_valid          <= 1'b0;
            sk_valid          <= 1'b0;
            slave_waitrequest <= 1'b0;
        end else begin
            or_valid          <= or_valid_nxt;
            sk_valid          <= sk_valid_nxt;
            slave_waitrequest <= sk_valid_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pending <= '0;
        end else begin
            case ({rd_issue, master_readdatavalid})
                2'b10:   pending <= pending + PW'(1);
                2'b01:   if (pending != '0) pending <= pending - PW'(1);
                default: pending <= pending;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            slave_readdata      <= '0;
            slave_readdatavalid <= 1'b0;
            slave_endofpacket   <= 1'b0;
        end else begin
            slave_readdata      <= master_readdata;
            slave_readdatavalid <= master_readdatavalid;
            slave_endofpacket   <= master_endofpacket;
        end
    end

endmodule

// File: tb/tb_cpu_ddr_pipeline_bridge.sv
// Directed self-checking bench for cpu_ddr_pipeline_bridge (default parameters).
module tb_cpu_ddr_pipeline_bridge;

    localparam int AW = 23;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] slave_address, slave_nativeaddress;
    logic [3:0]    slave_byteenable;
    logic          slave_read, slave_write;
    logic [31:0]   slave_writedata;
    logic          slave_waitrequest;
    logic [31:0]   slave_readdata;
    logic          slave_readdatavalid, slave_endofpacket;
    logic [AW-1:0] master_address, master_nativeaddress;
    logic [3:0]    master_byteenable;
    logic          master_read, master_write;
    logic [31:0]   master_writedata;
    logic          master_waitrequest;
    logic [31:0]   master_readdata;
    logic          master_readdatavalid, master_endofpacket;

    int checks = 0;
    int errors = 0;

    cpu_ddr_pipeline_bridge #(.MAX_PENDING_READS(8), .ADDR_W(AW)) dut (
        .clk(clk), .reset(reset),
        .slave_address(slave_address), .slave_nativeaddress(slave_nativeaddress),
        .slave_byteenable(slave_byteenable), .slave_read(slave_read),
        .slave_write(slave_write), .slave_writedata(slave_writedata),
        .slave_waitrequest(slave_waitrequest), .slave_readdata(slave_readdata),
        .slave_readdatavalid(slave_readdatavalid), .slave_endofpacket(slave_endofpacket),
        .master_address(master_address), .master_nativeaddress(master_nativeaddress),
        .master_byteenable(master_byteenable), .master_read(master_read),
        .master_write(master_write), .master_writedata(master_writedata),
        .master_waitrequest(master_waitrequest), .master_readdata(master_readdata),
        .master_readdatavalid(master_readdatavalid), .master_endofpacket(master_endofpacket)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        checks++; if (slave_waitrequest !== 1'b0) begin errors++; $display("FAIL rst_waitreq: got %b want 0", slave_waitrequest); end
        checks++; if (slave_readdatavalid !== 1'b0) begin errors++; $display("FAIL rst_rdv: got %b want 0", slave_readdatavalid); end
        checks++; if (slave_readdata !== 32'h0) begin errors++; $display("FAIL rst_rdata: got %h want 0", slave_readdata); end
        checks++; if (slave_endofpacket !== 1'b0) begin errors++; $display("FAIL rst_eop: got %b want 0", slave_endofpacket); end
        checks++; if ({master_read, master_write} !== 2'b00) begin errors++; $display("FAIL rst_mcmd: got %b want 00", {master_read, master_write}); end
        checks++; if (dut.pending !== 4'd0) begin errors++; $display("FAIL rst_pending: got %0d want 0", dut.pending); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_single_write();
        slave_address = 23'h000010; slave_nativeaddress = 23'h000010;
        slave_writedata = 32'hDEADBEEF; slave_byteenable = 4'hF; slave_write = 1'b1;
        tick();
        slave_write = 1'b0;
        checks++; if (master_write !== 1'b1) begin errors++; $display("FAIL sw_write: got %b want 1", master_write); end
        checks++; if (master_address !== 23'h000010) begin errors++; $display("FAIL sw_addr: got %h want 000010", master_address); end
        checks++; if (master_nativeaddress !== 23'h000010) begin errors++; $display("FAIL sw_naddr: got %h want 000010", master_nativeaddress); end
        checks++; if (master_writedata !== 32'hDEADBEEF) begin errors++; $display("FAIL sw_data: got %h want deadbeef", master_writedata); end
        checks++; if (master_byteenable !== 4'hF) begin errors++; $display("FAIL sw_be: got %h want f", master_byteenable); end
        checks++; if (master_read !== 1'b0) begin errors++; $display("FAIL sw_read: got %b want 0", master_read); end
        checks++; if (slave_waitrequest !== 1'b0) begin errors++; $display("FAIL sw_waitreq: got %b want 0", slave_waitrequest); end
        tick();
        checks++; if (master_write !== 1'b0) begin errors++; $display("FAIL sw_one_cycle: got %b want 0", master_write); end
    endtask

    task automatic test_stall();
        master_waitrequest = 1'b1;
        slave_byteenable = 4'h3;
        slave_address = 23'h000A01; slave_writedata = 32'h0000_0A01; slave_write = 1'b1;
        tick();
        checks++; if (slave_waitrequest !== 1'b0) begin errors++; $display("FAIL st_wr_after1: got %b want 0", slave_waitrequest); end
        slave_address = 23'h000A02; slave_writedata = 32'h0000_0A02;
        tick();
        checks++; if (slave_waitrequest !== 1'b1) begin errors++; $display("FAIL st_wr_after2: got %b want 1", slave_waitrequest); end
        slave_address = 23'h000A03; slave_writedata = 32'h0000_0A03;
        tick();
        checks++; if (slave_waitrequest !== 1'b1) begin errors++; $display("FAIL st_wr_held: got %b want 1", slave_waitrequest); end
        checks++; if (master_write !== 1'b1 || master_address !== 23'h000A01) begin errors++; $display("FAIL st_hold: got w=%b a=%h want w=1 a=000a01", master_write, master_address); end
        master_waitrequest = 1'b0;
        #1;
        checks++; if (master_write !== 1'b1 || master_writedata !== 32'h0000_0A01) begin errors++; $display("FAIL st_issue1: got w=%b d=%h want w=1 d=00000a01", master_write, master_writedata); end
        tick();
        checks++; if (master_write !== 1'b1 || master_address !== 23'h000A02) begin errors++; $display("FAIL st_issue2: got w=%b a=%h want w=1 a=000a02", master_write, master_address); end
        tick();
        slave_write = 1'b0;
        checks++; if (master_write !== 1'b1 || master_address !== 23'h000A03) begin errors++; $display("FAIL st_issue3: got w=%b a=%h want w=1 a=000a03", master_write, master_address); end
        tick();
        checks++; if (master_write !== 1'b0) begin errors++; $display("FAIL st_drained: got %b want 0", master_write); end
    endtask

    task automatic test_read_limit();
        int issued = 0;
        slave_byteenable = 4'hF;
        for (int i = 0; i < 9; i++) begin
            slave_address = 23'h000100 + 23'(i);
            slave_read = 1'b1;
            if (master_read && !master_waitrequest) issued++;
            tick();
        end
        slave_read = 1'b0;
        checks++; if (issued !== 8) begin errors++; $display("FAIL rl_issued: got %0d want 8", issued); end
        checks++; if (dut.pending !== 4'd8) begin errors++; $display("FAIL rl_pending: got %0d want 8", dut.pending); end
        checks++; if (master_read !== 1'b0 || master_address !== 23'h000108) begin errors++; $display("FAIL rl_block: got r=%b a=%h want r=0 a=000108", master_read, master_address); end
        tick();
        checks++; if (master_read !== 1'b0) begin errors++; $display("FAIL rl_still_block: got %b want 0", master_read); end
        master_readdatavalid = 1'b1; master_readdata = 32'h0000_0001;
        tick();
        master_readdatavalid = 1'b0;
        checks++; if (master_read !== 1'b1 || master_address !== 23'h000108) begin errors++; $display("FAIL rl_release: got r=%b a=%h want r=1 a=000108", master_read, master_address); end
        tick();
        checks++; if (dut.pending !== 4'd8 || master_read !== 1'b0) begin errors++; $display("FAIL rl_after: got p=%0d r=%b want p=8 r=0", dut.pending, master_read); end
    endtask

    task automatic test_response();
        master_readdatavalid = 1'b1; master_readdata = 32'h12345678; master_endofpacket = 1'b1;
        tick();
        master_readdatavalid = 1'b0; master_readdata = 32'h0; master_endofpacket = 1'b0;
        checks++; if (slave_readdatavalid !== 1'b1 || slave_readdata !== 32'h12345678 || slave_endofpacket !== 1'b1) begin
            errors++; $display("FAIL rsp_fwd: got v=%b d=%h e=%b want v=1 d=12345678 e=1", slave_readdatavalid, slave_readdata, slave_endofpacket);
        end
        checks++; if (dut.pending !== 4'd7) begin errors++; $display("FAIL rsp_pending: got %0d want 7", dut.pending); end
        slave_address = 23'h000200; slave_read = 1'b1;
        tick();
        slave_read = 1'b0;
        checks++; if (slave_readdatavalid !== 1'b0) begin errors++; $display("FAIL rsp_one_cycle: got %b want 0", slave_readdatavalid); end
        checks++; if (master_read !== 1'b1) begin errors++; $display("FAIL rsp_sim_issue: got %b want 1", master_read); end
        master_readdatavalid = 1'b1;
        tick();
        master_readdatavalid = 1'b0;
        checks++; if (dut.pending !== 4'd7) begin errors++; $display("FAIL rsp_sim_pending: got %0d want 7", dut.pending); end
        master_readdatavalid = 1'b1;
        for (int i = 0; i < 7; i++) tick();
        master_readdatavalid = 1'b0;
        checks++; if (dut.pending !== 4'd0) begin errors++; $display("FAIL rsp_drain: got %0d want 0", dut.pending); end
    endtask

    task automatic test_rw_both();
        slave_address = 23'h000300; slave_writedata = 32'h55AA55AA;
        slave_read = 1'b1; slave_write = 1'b1;
        tick();
        slave_read = 1'b0; slave_write = 1'b0;
        checks++; if (master_write !== 1'b1 || master_read !== 1'b0 || master_address !== 23'h000300) begin
            errors++; $display("FAIL rw_cmd: got w=%b r=%b a=%h want w=1 r=0 a=000300", master_write, master_read, master_address);
        end
        tick();
        checks++; if ({master_write, master_read} !== 2'b00 || dut.pending !== 4'd0) begin
            errors++; $display("FAIL rw_after: got wr=%b p=%0d want wr=00 p=0", {master_write, master_read}, dut.pending);
        end
        master_readdatavalid = 1'b1; master_readdata = 32'hCAFEF00D;
        tick();
        master_readdatavalid = 1'b0;
        checks++; if (slave_readdatavalid !== 1'b1 || slave_readdata !== 32'hCAFEF00D || dut.pending !== 4'd0) begin
            errors++; $display("FAIL spurious: got v=%b d=%h p=%0d want v=1 d=cafef00d p=0", slave_readdatavalid, slave_readdata, dut.pending);
        end
    endtask

    task automatic test_reset_mid_stall();
        slave_address = 23'h000400; slave_read = 1'b1;
        tick();
        slave_read = 1'b0;
        tick();
        master_waitrequest = 1'b1;
        slave_address = 23'h000401; slave_writedata = 32'h0000_0401; slave_write = 1'b1;
        tick();
        slave_write = 1'b0; slave_address = 23'h000402; slave_read = 1'b1;
        tick();
        slave_read = 1'b0;
        checks++; if (slave_waitrequest !== 1'b1 || dut.pending !== 4'd1) begin
            errors++; $display("FAIL rm_setup: got wq=%b p=%0d want wq=1 p=1", slave_waitrequest, dut.pending);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0; master_waitrequest = 1'b0;
        checks++; if ({master_read, master_write} !== 2'b00 || slave_waitrequest !== 1'b0 || dut.pending !== 4'd0) begin
            errors++; $display("FAIL rm_reset: got rw=%b wq=%b p=%0d want rw=00 wq=0 p=0", {master_read, master_write}, slave_waitrequest, dut.pending);
        end
        tick();
        checks++; if ({master_read, master_write} !== 2'b00) begin errors++; $display("FAIL rm_post: got %b want 00", {master_read, master_write}); end
    endtask

    initial begin
        reset = 1'b1;
        slave_address = '0; slave_nativeaddress = '0; slave_byteenable = '0;
        slave_read = 1'b0; slave_write = 1'b0; slave_writedata = '0;
        master_waitrequest = 1'b0; master_readdata = '0;
        master_readdatavalid = 1'b0; master_endofpacket = 1'b0;
        #1;
        test_reset();
        test_single_write();
        test_stall();
        test_read_limit();
        test_response();
        test_rw_both();
        test_reset_mid_stall();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
